rf_wb_arbiter: RTL
==================

# rf_wb_arbiter

Shares the register file's single write port (`we3`/`ad3`/`wd3`) between `NREQ` writeback requesters (ALU writeback, load return, trigger/CSR side-writes). It grants one requester per cycle round-robin over a valid/ready handshake and registers the winning write into a one-entry output stage that drives the register file. It also exports a pending-destination bitmap so decode can stall on RAW hazards.

## Interface
- `NREQ`, 3: number of write requesters; 2–8.
- `A_WIDTH`, 5: register address width.
- `D_WIDTH`, 32: data width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  requester i has a write pending.
- `req_addr`  in  NREQ*A_WIDTH  destination of requester i, in slice [i*A_WIDTH +: A_WIDTH].
- `req_data`  in  NREQ*D_WIDTH  write data of requester i, in slice [i*D_WIDTH +: D_WIDTH].
- `req_ready`  out  NREQ  one-hot grant; a write transfers when valid and ready are both high in the same cycle.
- `we3`  out  1  register file write enable.
- `ad3`  out  A_WIDTH  register file write address.
- `wd3`  out  D_WIDTH  register file write data.
- `grant_id`  out  $clog2(NREQ)  index of the requester held in the output stage.
- `pending`  out  2**A_WIDTH  bit r is set when register r is a destination that is not yet written.
- `ad1`, `ad2`  in  A_WIDTH  read addresses. Present only with the macro defined.
- `rd1_rf`, `rd2_rf`  in  D_WIDTH  raw register file read data. Present only with the macro defined.
- `rd1`, `rd2`  out  D_WIDTH  forwarded read data. Present only with the macro defined.

## Operation
- **Round-robin pointer `last`**, width $clog2(NREQ).
  - Search order is last+1, last+2, … modulo NREQ.
  - The first valid requester in that order wins.
  - On each grant, `last` becomes the winner's index.
  - Reset value is NREQ-1, so requester 0 wins first.
- **Grant path**
  - `req_ready` is combinational from `req_valid` and `last`.
  - At most one bit of `req_ready` is set, and only for a valid requester.
  - With no valid requester, `req_ready` is 0.
- **Requester contract**
  - Once `req_valid` rises, the requester holds valid, addr and data stable until its ready is seen.
  - The arbiter does not check this contract.
- **Output stage**
  - It never back-pressures, because the register file accepts a write every cycle.
  - On a grant, the next edge loads `ad3` and `wd3` from the winner and loads `grant_id`.
  - `we3` is set to 1 on a grant, except when the winning address is 0.
  - With no grant, `we3` goes to 0 and `ad3`, `wd3` and `grant_id` hold.
- **x0 writes**: a grant to address 0 completes the handshake and is dropped (`we3` stays 0).
- **`pending`** is the OR of:
  - decoded `req_addr` for every valid requester;
  - decoded `ad3` when `we3` is 1.
  - Bit 0 is always 0.
- **Same-address collisions**
  - Two requesters targeting the same register in one cycle are serialized in grant order; the last one written wins.
  - The bit in `pending` stays set until both writes complete.

## Timing
- Reset values: `we3`=0, `ad3`=0, `wd3`=0, `grant_id`=0, `last`=NREQ-1. `req_ready` and `pending` derive from these registers and the inputs.
- Handshake to `we3` is 1 cycle. The register file commits on the following edge, so the total from handshake to architectural write is 2 edges.
- Throughput is one write per cycle with no bubbles under continuous demand.
- Fairness bound: with all NREQ requesters valid, each waits at most NREQ-1 cycles for a grant.
- Reset asserted mid-operation:
  - The output stage is cleared immediately (asynchronously), so an in-flight write is lost.
  - Requesters must re-present after reset; no write may occur while `rst_n`=0.

## Configuration
- `RF_WB_FWD_EN` defined: the forwarding ports exist.
  - `rd1` = `wd3` when `we3` is 1 and `ad1`==`ad3`; otherwise `rd1` = `rd1_rf`. `rd2` follows the same rule with `ad2`.
  - Address 0 is never forwarded, because `we3` is never 1 for address 0.
  - This removes the write-then-read stall, since decode reads the value being written in the same cycle.
- `RF_WB_FWD_EN` undefined: the forwarding ports are absent.
  - Decode must stall on `pending` bits until `we3` has dropped for that address.

## Test plan
- **Single writer:** after reset, `req_valid`=3'b001 with addr 5, data 0xDEADBEEF.
  - Same cycle: `req_ready`=3'b001.
  - Next cycle: `we3`=1, `ad3`=5, `wd3`=0xDEADBEEF, `grant_id`=0.
  - Cycle after: `we3`=0.
- **Round-robin fairness:** all three valid and held, with addresses 1, 2, 3.
  - Grant order is 0, 1, 2, 0, …
  - `ad3` sequence is 1, 2, 3, 1.
- **x0 drop:** requester 1 writes addr 0, data 0x55.
  - `req_ready`[1]=1 and the handshake completes.
  - `we3` stays 0 throughout.
  - `pending`[0] stays 0.
- **Collision:** requesters 0 and 2 both target addr 9 with data 0x1 and 0x2.
  - Two consecutive writes with `ad3`=9, in grant order.
  - `pending`[9] is set from the first cycle until `we3` drops.
- **Reset mid-flight:** assert `rst_n`=0 while `we3`=1.
  - `we3`, `ad3`, `wd3` and `grant_id` go to 0 immediately, without waiting for a clock edge.
  - After release, requester 0 is granted first.
- **Forwarding (`RF_WB_FWD_EN`):** `we3`=1, `ad3`=7, `wd3`=0xA5A5A5A5, `ad1`=7, `ad2`=8, `rd1_rf`=0, `rd2_rf`=0x11.
  - Expected `rd1`=0xA5A5A5A5 and `rd2`=0x11.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_arbiter
// Brief    : Round-robin arbiter sharing the register file write port among
//            NREQ writeback requesters, with a registered output stage and a
//            pending-destination bitmap. RF_WB_FWD_EN adds read forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter #(
    parameter  int NREQ    = 3,
    parameter  int A_WIDTH = 5,
    parameter  int D_WIDTH = 32,
    localparam int IDW     = $clog2(NREQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*A_WIDTH-1:0]   req_addr,
    input  logic [NREQ*D_WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic                      we3,
    output logic [A_WIDTH-1:0]        ad3,
    output logic [D_WIDTH-1:0]        wd3,
    output logic [IDW-1:0]            grant_id,
`ifdef RF_WB_FWD_EN
    input  logic [A_WIDTH-1:0]        ad1,
    input  logic [A_WIDTH-1:0]        ad2,
    input  logic [D_WIDTH-1:0]        rd1_rf,
    input  logic [D_WIDTH-1:0]        rd2_rf,
    output logic [D_WIDTH-1:0]        rd1,
    output logic [D_WIDTH-1:0]        rd2,
`endif
    output logic [2**A_WIDTH-1:0]     pending
);

    localparam logic [IDW-1:0] c_LAST_RST = IDW'(NREQ - 1);

    logic                 r_we3;
    logic [A_WIDTH-1:0]   r_ad3;
    logic [D_WIDTH-1:0]   r_wd3;
    logic [IDW-1:0]       r_grant_id;
    logic [IDW-1:0]       r_last;

    logic                 w_found;
    logic [IDW-1:0]       w_win;
    logic [IDW-1:0]       w_idx;
    logic [NREQ-1:0]      w_grant;
    logic [A_WIDTH-1:0]   w_addr;
    logic [D_WIDTH-1:0]   w_data;
    logic [2**A_WIDTH-1:0] w_pending;

    // First valid requester searching from last+1 upward, wrapping at NREQ.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        w_grant = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = IDW'((int'(r_last) + k) % NREQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
        w_grant[w_win] = w_found;
    end

    assign w_addr    = req_addr[w_win*A_WIDTH +: A_WIDTH];
    assign w_data    = req_data[w_win*D_WIDTH +: D_WIDTH];
    assign req_ready = w_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we3      <= 1'b0;
            r_ad3      <= '0;
            r_wd3      <= '0;
            r_grant_id <= '0;
            r_last     <= c_LAST_RST;
        end else if (w_found) begin
            // x0 grants complete the handshake but never reach the file.
            r_we3      <= (w_addr != '0);
            r_ad3      <= w_addr;
            r_wd3      <= w_data;
            r_grant_id <= w_win;
            r_last     <= w_win;
        end else begin
            r_we3      <= 1'b0;
        end
    end

    always_comb begin
        w_pending = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i]) begin
                w_pending[req_addr[i*A_WIDTH +: A_WIDTH]] = 1'b1;
            end
        end
        if (r_we3) begin
            w_pending[r_ad3] = 1'b1;
        end
        w_pending[0] = 1'b0;
    end

    assign pending  = w_pending;
    assign we3      = r_we3;
    assign ad3      = r_ad3;
    assign wd3      = r_wd3;
    assign grant_id = r_grant_id;

`ifdef RF_WB_FWD_EN
    assign rd1 = (r_we3 && (ad1 == r_ad3)) ? r_wd3 : rd1_rf;
    assign rd2 = (r_we3 && (ad2 == r_ad3)) ? r_wd3 : rd2_rf;
`endif

endmodule
`default_nettype wire
